// File: rtl/regbank_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_pkg
//  Purpose  : Shared types and helpers for the register-bank write side:
//             register index type, writeback request record and the rd to
//             one-hot write-strobe decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package regbank_pkg;

    localparam int NREG  = 32;
    localparam int REG_W = 32;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t           rd;
        logic [REG_W-1:0]   data;
    } wb_req_t;

    // x0 has no strobe bit, so rd==0 decodes to an all-zero strobe.
    function automatic logic [NREG-1:1] onehot_rd(input reg_idx_t rd);
        logic [NREG-1:1] oh;
        for (int i = 1; i < NREG; i++) begin
            oh[i] = (rd == reg_idx_t'(i));
        end
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regbank_wb_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : DEPTH-entry synchronous FIFO of writeback requests, used to
//             buffer load results until the bank write port is free.
//  Ports    : clk, reset (async, active-low)
//             push_i/push_data_i  enqueue (ignored when full)
//             pop_i               dequeue head (ignored when empty)
//             head_o              current head entry
//             full_o/empty_o      occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regbank_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push_i,
    input  wb_req_t push_data_i,
    input  logic    pop_i,
    output wb_req_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/regbank_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_wb_arbiter
//  Purpose  : Write-side controller for the 31-entry register bank. Merges
//             ALU and load writebacks onto the single write port (ALU first,
//             queued loads otherwise, with a starvation stall on the ALU),
//             drives the registered one-hot strobe and bypasses the write in
//             flight onto both read ports.
//  Ports    : clk, reset (async, active-low)
//             alu_valid/alu_rd/alu_data  ALU writeback, held until accepted
//             alu_stall                  ALU result not accepted this cycle
//             ld_valid/ld_rd/ld_data     load writeback, ld_ready = not full
//             addrw/wdata                registered bank write port
//             addra/addrb, rf_outa/rf_outb  bank read ports
//             fwd_outa/fwd_outb          bypassed read data
//  Note     : DATA_W must equal regbank_pkg::REG_W.
//  Revision : 1.0 - initial release
// ============================================================================
module regbank_wb_arbiter
    import regbank_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_stall,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [4:0]        ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic [31:1]       addrw,
    output logic [DATA_W-1:0] wdata,
    input  logic [4:0]        addra,
    input  logic [4:0]        addrb,
    input  logic [DATA_W-1:0] rf_outa,
    input  logic [DATA_W-1:0] rf_outb,
    output logic [DATA_W-1:0] fwd_outa,
    output logic [DATA_W-1:0] fwd_outb
);

    localparam int               CNT_W      = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT - 1);

    wb_req_t           ld_req;
    wb_req_t           lq_head;
    logic              lq_full;
    logic              lq_empty;
    logic              lq_push;
    logic              grant_alu;
    logic              grant_ld;
    logic              head_wait;

    logic [31:1]       addrw_q,      addrw_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic              alu_stall_q,  alu_stall_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0]       addrw_ext;

    assign ld_req   = '{rd: ld_rd, data: ld_data};
    assign ld_ready = !lq_full;
    assign lq_push  = ld_valid && ld_ready;

    wb_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk         (clk),
        .reset       (reset),
        .push_i      (lq_push),
        .push_data_i (ld_req),
        .pop_i       (grant_ld),
        .head_o      (lq_head),
        .full_o      (lq_full),
        .empty_o     (lq_empty)
    );

    always_comb begin
        grant_alu    = alu_valid && !alu_stall_q;
        grant_ld     = !grant_alu && !lq_empty;
        head_wait    = !lq_empty && !grant_ld;

        // Counter saturates: the stall it triggers always grants the head,
        // which clears it the following cycle.
        starve_cnt_d = '0;
        if (head_wait) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q
                                                        : starve_cnt_q + CNT_W'(1);
        end
        alu_stall_d  = head_wait && (starve_cnt_q == STARVE_MAX);

        // wdata keeps its last value on idle cycles; only addrw qualifies it.
        addrw_d = '0;
        wdata_d = wdata_q;
        if (grant_alu) begin
            addrw_d = onehot_rd(alu_rd);
            wdata_d = alu_data;
        end else if (grant_ld) begin
            addrw_d = onehot_rd(lq_head.rd);
            wdata_d = lq_head.data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addrw_q      <= '0;
            wdata_q      <= '0;
            alu_stall_q  <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            addrw_q      <= addrw_d;
            wdata_q      <= wdata_d;
            alu_stall_q  <= alu_stall_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign addrw     = addrw_q;
    assign wdata     = wdata_q;
    assign alu_stall = alu_stall_q;

    // Bit 0 of the extended strobe is tied low, so address 0 never bypasses.
    assign addrw_ext = {addrw_q, 1'b0};
    assign fwd_outa  = addrw_ext[addra] ? wdata_q : rf_outa;
    assign fwd_outb  = addrw_ext[addrb] ? wdata_q : rf_outb;

endmodule
`default_nettype wire

// File: tb/tb_regbank_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbank_wb_arbiter
//  Purpose  : Randomised scoreboard bench for regbank_wb_arbiter with a
//             queue-based reference model and a behavioural register bank.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_wb_arbiter;

    localparam int LQ_DEPTH     = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd    = '0;
    logic [31:0] alu_data  = '0;
    logic        alu_stall;
    logic        ld_valid  = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd     = '0;
    logic [31:0] ld_data   = '0;
    logic [31:1] addrw;
    logic [31:0] wdata;
    logic [4:0]  addra = '0;
    logic [4:0]  addrb = '0;
    logic [31:0] rf_outa;
    logic [31:0] rf_outb;
    logic [31:0] fwd_outa;
    logic [31:0] fwd_outb;

    always #5 clk = ~clk;

    regbank_wb_arbiter #(
        .DATA_W       (32),
        .LQ_DEPTH     (LQ_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .addrw     (addrw),
        .wdata     (wdata),
        .addra     (addra),
        .addrb     (addrb),
        .rf_outa   (rf_outa),
        .rf_outb   (rf_outb),
        .fwd_outa  (fwd_outa),
        .fwd_outb  (fwd_outb)
    );

    typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } wr_t;
    typedef struct { int cyc; logic stall; logic ready; } st_t;

    wr_t exp_wr[$];     // expected bank writes, stamped with the visible cycle
    st_t exp_st[$];     // expected alu_stall / ld_ready per cycle
    wr_t lq[$];         // model of the load queue

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural bank: what the DUT actually wrote; reference: what it should have.
    logic [31:0] bank   [32] = '{default: 32'h0};
    logic [31:0] ref_rf [32] = '{default: 32'h0};

    assign rf_outa = bank[addra];
    assign rf_outb = bank[addrb];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                if (addrw[i]) bank[i] <= wdata;
            end
        end
    end

    // Stimulus / model state
    logic        m_stall = 1'b0;
    int          m_wait  = 0;
    logic        alu_pend = 1'b0;
    logic [4:0]  alu_rd_v = '0;
    logic [31:0] alu_dat_v = '0;
    logic        ld_pend = 1'b0;
    logic [4:0]  ld_rd_v = '0;
    logic [31:0] ld_dat_v = '0;
    int          p_alu = 0;
    int          p_ld  = 0;
    int          rd_mode = 0;
    int          force_a = -1;
    int          force_b = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [31:1] exp_onehot(input logic [4:0] rd);
        logic [31:0] t;
        t = 32'd1 << rd;
        return t[31:1];
    endfunction

    function automatic logic [4:0] pick_rd();
        case (rd_mode)
            0:       return 5'($urandom_range(1, 31));
            1:       return 5'($urandom_range(0, 3));
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    // One cycle: drive inputs, then advance the reference model by the
    // decisions this cycle's inputs cause at the next rising edge.
    task automatic step();
        wr_t  w;
        logic ready, alu_take, head_take, next_stall;
        if (!alu_pend && ($urandom_range(0, 99) < p_alu)) begin
            alu_pend  = 1'b1;
            alu_rd_v  = pick_rd();
            alu_dat_v = $urandom();
        end
        if (!ld_pend && ($urandom_range(0, 99) < p_ld)) begin
            ld_pend  = 1'b1;
            ld_rd_v  = pick_rd();
            ld_dat_v = $urandom();
        end
        alu_valid = alu_pend;
        alu_rd    = alu_rd_v;
        alu_data  = alu_dat_v;
        ld_valid  = ld_pend;
        ld_rd     = ld_rd_v;
        ld_data   = ld_dat_v;

        if (force_a >= 0) addra = 5'(force_a);
        else if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc && $urandom_range(0, 1) == 1)
            addra = exp_wr[0].rd;
        else addra = 5'($urandom_range(0, 31));
        if (force_b >= 0) addrb = 5'(force_b);
        else if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc && $urandom_range(0, 1) == 1)
            addrb = exp_wr[0].rd;
        else addrb = 5'($urandom_range(0, 31));
        force_a = -1;
        force_b = -1;

        ready = (lq.size() < LQ_DEPTH);
        exp_st.push_back('{cyc, m_stall, ready});

        alu_take  = alu_pend && !m_stall;
        head_take = !alu_take && (lq.size() > 0);
        next_stall = (lq.size() > 0) && !head_take && (m_wait == STARVE_LIMIT - 1);
        m_wait     = ((lq.size() == 0) || head_take) ? 0 : m_wait + 1;

        w = '{0, 5'd0, 32'h0};
        if (alu_take) begin
            w = '{cyc + 1, alu_rd_v, alu_dat_v};
            alu_pend = 1'b0;
        end else if (head_take) begin
            w = lq.pop_front();
            w.cyc = cyc + 1;
        end
        if ((alu_take || head_take) && w.rd != 5'd0) exp_wr.push_back(w);

        if (ld_pend && ready) begin
            lq.push_back('{0, ld_rd_v, ld_dat_v});
            ld_pend = 1'b0;
        end
        m_stall = next_stall;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            step();
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        lq.delete();
        exp_wr.delete();
        exp_st.delete();
        m_stall  = 1'b0;
        m_wait   = 0;
        alu_pend = 1'b0;
        ld_pend  = 1'b0;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        step();
    endtask

    // Monitor: compares DUT outputs against queued expectations each cycle.
    initial begin
        wr_t         e;
        st_t         s;
        logic        have;
        logic [31:0] fa, fb;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("reset_addrw", 64'(addrw), 64'd0);
                check("reset_stall", 64'(alu_stall), 64'd0);
                check("reset_ready", 64'(ld_ready), 64'd1);
            end else begin
                if (exp_st.size() > 0 && exp_st[0].cyc == cyc) begin
                    s = exp_st.pop_front();
                    check("alu_stall", 64'(alu_stall), 64'(s.stall));
                    check("ld_ready", 64'(ld_ready), 64'(s.ready));
                end else begin
                    check("status_expected", 64'd0, 64'd1);
                end
                have = (exp_wr.size() > 0 && exp_wr[0].cyc == cyc);
                if (have) begin
                    e = exp_wr.pop_front();
                    check("addrw", 64'(addrw), 64'(exp_onehot(e.rd)));
                    check("wdata", 64'(wdata), 64'(e.data));
                    ref_rf[e.rd] = e.data;
                end else begin
                    check("idle_addrw", 64'(addrw), 64'd0);
                end
                fa = (have && addra != 5'd0 && e.rd == addra) ? e.data : bank[addra];
                fb = (have && addrb != 5'd0 && e.rd == addrb) ? e.data : bank[addrb];
                check("fwd_outa", 64'(fwd_outa), 64'(fa));
                check("fwd_outb", 64'(fwd_outb), 64'(fb));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        // Single ALU write to x5.
        alu_pend = 1'b1; alu_rd_v = 5'd5; alu_dat_v = 32'hDEADBEEF;
        run(1);
        run(3);
        check("x5_bank", 64'(bank[5]), 64'hDEADBEEF);

        // Bypass of a write to x7 on port A; port B reads x8 from the bank.
        alu_pend = 1'b1; alu_rd_v = 5'd7; alu_dat_v = 32'h000055AA;
        run(1);
        force_a = 7; force_b = 8;
        run(1);
        run(2);

        // x0 writes from both sources are consumed but never strobe.
        alu_pend = 1'b1; alu_rd_v = 5'd0; alu_dat_v = 32'h1;
        ld_pend  = 1'b1; ld_rd_v  = 5'd0; ld_dat_v  = 32'h2;
        force_a = 0; force_b = 0;
        run(1);
        force_a = 0; force_b = 0;
        run(4);

        // Saturated ALU and load traffic: queue fills, starvation stalls.
        p_alu = 100; p_ld = 100; rd_mode = 0;
        run(60);

        // Heavy x0 and same-register traffic.
        p_alu = 50; p_ld = 50; rd_mode = 1;
        run(100);

        // Mid-stream reset under full load.
        p_alu = 100; p_ld = 100; rd_mode = 2;
        run(7);
        apply_reset();
        run(30);

        for (int k = 0; k < 8; k++) begin
            p_alu = $urandom_range(0, 100);
            p_ld  = $urandom_range(0, 100);
            rd_mode = $urandom_range(0, 2);
            run(25);
        end

        p_alu = 0; p_ld = 0;
        run(12);
        check("drain_empty", 64'(exp_wr.size() + lq.size()), 64'd0);
        for (int i = 0; i < 32; i++) begin
            check("bank_final", 64'(bank[i]), 64'(ref_rf[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
